// File: rtl/uart_cmd_assembler.sv
// Assembles UART receiver bytes into 16-bit commands, high byte first.
// Define CMD_TIMEOUT_EN to compile in the inter-byte timeout that drops a stale high byte.
module uart_cmd_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 260416
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_rdy_i,
    input  logic [7:0]  rx_data_i,
    output logic        clr_rx_rdy_o,
    input  logic        clr_cmd_rdy_i,
    output logic [15:0] cmd_o,
    output logic        cmd_rdy_o,
    output logic        cmd_ovr_o,
    output logic        cmd_tmo_o
);

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] cmd_q, cmd_d;
    logic        rdy_q, rdy_d;
    logic        ovr_q, ovr_d;
    logic        expire;

    // Every offered byte is consumed in the cycle it is seen, so the ack is a wire.
    assign clr_rx_rdy_o = rx_rdy_i;

`ifdef CMD_TIMEOUT_EN
    localparam logic [17:0] CntLast = 18'(TIMEOUT_CYCLES - 1);

    logic [17:0] cnt_q, cnt_d;
    logic        tmo_q;

    // An arriving byte takes priority over expiry in the same cycle.
    assign expire = (state_q == WAIT_LO) && !rx_rdy_i && (cnt_q == CntLast);

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT_LO && !rx_rdy_i && !expire) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 18'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= expire;
        end
    end

    assign cmd_tmo_o = tmo_q;
`else
    assign expire    = 1'b0;
    assign cmd_tmo_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        cmd_d   = cmd_q;
        rdy_d   = rdy_q;
        ovr_d   = ovr_q;
        if (clr_cmd_rdy_i) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
        unique case (state_q)
            WAIT_HI: begin
                if (rx_rdy_i) begin
                    hi_d    = rx_data_i;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // A completion overrides a simultaneous acknowledge.
                if (rx_rdy_i) begin
                    cmd_d   = {hi_q, rx_data_i};
                    rdy_d   = 1'b1;
                    ovr_d   = rdy_q & ~clr_cmd_rdy_i;
                    state_d = WAIT_HI;
                end else if (expire) begin
                    hi_d    = 8'h00;
                    state_d = WAIT_HI;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_HI;
            hi_q    <= 8'h00;
            cmd_q   <= 16'h0000;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cmd_o     = cmd_q;
    assign cmd_rdy_o = rdy_q;
    assign cmd_ovr_o = ovr_q;

endmodule
